// File: rtl/ras_ckpt_pkg.sv
// Shared return-address-stack types: default geometry, the checkpoint
// record kept by the BRU/ROB, and the per-cycle request decode.
`timescale 1ns/1ps
package ras_ckpt_pkg;

  localparam int RAS_ENTRIES      = 8;
  localparam int RAS_TARGET_WIDTH = 31;
  localparam int LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES);

  // Snapshot taken at branch prediction time, replayed on a mispredict.
  typedef struct packed {
    logic [LOG_RAS_ENTRIES-1:0]  tos;
    logic [LOG_RAS_ENTRIES:0]    count;
    logic [RAS_TARGET_WIDTH-1:0] target;
  } ras_ckpt_t;

  typedef enum logic [2:0] {
    RAS_OP_IDLE,
    RAS_OP_RESTORE,
    RAS_OP_PUSH,
    RAS_OP_POP,
    RAS_OP_PUSHPOP
  } ras_op_e;

  // Restore overrides everything; push+pop together is a tail-call replace.
  function automatic ras_op_e ras_decode(input logic restore, input logic push,
                                         input logic pop);
    if (restore)          return RAS_OP_RESTORE;
    else if (push && pop) return RAS_OP_PUSHPOP;
    else if (push)        return RAS_OP_PUSH;
    else if (pop)         return RAS_OP_POP;
    else                  return RAS_OP_IDLE;
  endfunction

endpackage

// File: rtl/ras_ckpt.sv
// Checkpoint-repairable return address stack. Flop-based storage with a
// modulo pointer; the backend can restore tos, count and the top entry.
`timescale 1ns/1ps
module ras_ckpt #(
  parameter int RAS_ENTRIES      = ras_ckpt_pkg::RAS_ENTRIES,
  parameter int RAS_TARGET_WIDTH = ras_ckpt_pkg::RAS_TARGET_WIDTH,
  parameter int LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES),
  parameter bit OVERFLOW_WRAP    = 1'b1
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  output logic [RAS_TARGET_WIDTH-1:0] top_target,
  output logic                        top_valid,
  output logic [LOG_RAS_ENTRIES-1:0]  tos,
  output logic [LOG_RAS_ENTRIES:0]    count,
  input  logic                        restore_valid,
  input  logic [LOG_RAS_ENTRIES-1:0]  restore_tos,
  input  logic [LOG_RAS_ENTRIES:0]    restore_count,
  input  logic [RAS_TARGET_WIDTH-1:0] restore_target,
  output logic                        overflow_event
);
  import ras_ckpt_pkg::*;

  localparam logic [LOG_RAS_ENTRIES:0] FULL_COUNT = (LOG_RAS_ENTRIES+1)'(RAS_ENTRIES);

  logic [RAS_TARGET_WIDTH-1:0] entry [RAS_ENTRIES];

  logic [LOG_RAS_ENTRIES-1:0]  tos_inc;
  logic [LOG_RAS_ENTRIES-1:0]  tos_dec;
  logic                        full;
  ras_op_e                     op;

  logic [LOG_RAS_ENTRIES-1:0]  tos_nxt;
  logic [LOG_RAS_ENTRIES:0]    count_nxt;
  logic                        wr_en;
  logic [LOG_RAS_ENTRIES-1:0]  wr_idx;
  logic [RAS_TARGET_WIDTH-1:0] wr_data;
  logic                        ovf_nxt;

  // Pointer wraps naturally in the LOG_RAS_ENTRIES-bit field.
  assign tos_inc    = tos + 1'b1;
  assign tos_dec    = tos - 1'b1;
  assign full       = (count == FULL_COUNT);
  assign op         = ras_decode(restore_valid, push_valid, pop_valid);
  assign top_target = entry[tos];
  assign top_valid  = (count != '0);

  // Next-state decode: one storage write port, pointer/count update, overflow flag.
  always_comb begin
    tos_nxt   = tos;
    count_nxt = count;
    wr_en     = 1'b0;
    wr_idx    = tos;
    wr_data   = push_target;
    ovf_nxt   = 1'b0;
    case (op)
      RAS_OP_RESTORE: begin
        tos_nxt   = restore_tos;
        count_nxt = restore_count;
        wr_en     = 1'b1;
        wr_idx    = restore_tos;
        wr_data   = restore_target;
      end
      RAS_OP_PUSH: begin
        if (!full) begin
          tos_nxt   = tos_inc;
          count_nxt = count + 1'b1;
          wr_en     = 1'b1;
          wr_idx    = tos_inc;
        end else begin
          ovf_nxt = 1'b1;
          // Circular mode drops the oldest entry; count stays saturated.
          if (OVERFLOW_WRAP) begin
            tos_nxt = tos_inc;
            wr_en   = 1'b1;
            wr_idx  = tos_inc;
          end
        end
      end
      RAS_OP_POP: begin
        // Underflow still moves the pointer so speculative return chains stay aligned.
        tos_nxt = tos_dec;
        if (count != '0) count_nxt = count - 1'b1;
      end
      RAS_OP_PUSHPOP: begin
        wr_en  = 1'b1;
        wr_idx = tos;
        if (count == '0) count_nxt = (LOG_RAS_ENTRIES+1)'(1);
      end
      default: ;
    endcase
  end

  // State and storage registers; async active-low reset clears everything.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tos            <= '0;
      count          <= '0;
      overflow_event <= 1'b0;
      for (int i = 0; i < RAS_ENTRIES; i++) entry[i] <= '0;
    end else begin
      tos            <= tos_nxt;
      count          <= count_nxt;
      overflow_event <= ovf_nxt;
      if (wr_en) entry[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_ras_ckpt.sv
// Scoreboard bench for ras_ckpt: stimulus queues hand-computed expectations,
// a monitor compares them one cycle later. Two instances cover both overflow modes.
`timescale 1ns/1ps
module tb_ras_ckpt;

  localparam int W = 31;

  logic         CLK = 1'b0;
  logic         nRST;

  logic         a_push, a_pop, a_rv;
  logic [W-1:0] a_pt, a_rtgt, a_top;
  logic [2:0]   a_rtos, a_tos;
  logic [3:0]   a_rcnt, a_cnt;
  logic         a_vld, a_ovf;

  logic         b_push, b_pop, b_rv;
  logic [W-1:0] b_pt, b_rtgt, b_top;
  logic [2:0]   b_rtos, b_tos;
  logic [3:0]   b_rcnt, b_cnt;
  logic         b_vld, b_ovf;

  always #5 CLK = ~CLK;

  ras_ckpt #(.RAS_ENTRIES(8), .RAS_TARGET_WIDTH(W), .OVERFLOW_WRAP(1'b1)) u_wrap (
    .CLK(CLK), .nRST(nRST), .push_valid(a_push), .push_target(a_pt), .pop_valid(a_pop),
    .top_target(a_top), .top_valid(a_vld), .tos(a_tos), .count(a_cnt),
    .restore_valid(a_rv), .restore_tos(a_rtos), .restore_count(a_rcnt),
    .restore_target(a_rtgt), .overflow_event(a_ovf));

  ras_ckpt #(.RAS_ENTRIES(8), .RAS_TARGET_WIDTH(W), .OVERFLOW_WRAP(1'b0)) u_drop (
    .CLK(CLK), .nRST(nRST), .push_valid(b_push), .push_target(b_pt), .pop_valid(b_pop),
    .top_target(b_top), .top_valid(b_vld), .tos(b_tos), .count(b_cnt),
    .restore_valid(b_rv), .restore_tos(b_rtos), .restore_count(b_rcnt),
    .restore_target(b_rtgt), .overflow_event(b_ovf));

  typedef struct {
    string        name;
    bit           inst;
    logic [W-1:0] top;
    logic         vld;
    logic [2:0]   tos;
    logic [3:0]   cnt;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_outs(input string nm, input bit inst, input logic [W-1:0] et,
                            input logic ev, input logic [2:0] etos, input logic [3:0] ecnt,
                            input logic eo);
    logic [W-1:0] t;
    logic v, o;
    logic [2:0] p;
    logic [3:0] c;
    t = inst ? b_top : a_top;
    v = inst ? b_vld : a_vld;
    p = inst ? b_tos : a_tos;
    c = inst ? b_cnt : a_cnt;
    o = inst ? b_ovf : a_ovf;
    checks++;
    if ({t, v, p, c, o} !== {et, ev, etos, ecnt, eo}) begin
      errors++;
      $display("FAIL %s: got top=%h vld=%b tos=%0d count=%0d ovf=%b, want top=%h vld=%b tos=%0d count=%0d ovf=%b",
               nm, t, v, p, c, o, et, ev, etos, ecnt, eo);
    end
  endtask

  // Monitor: the DUT presents its result one cycle after each issued request.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_outs(e.name, e.inst, e.top, e.vld, e.tos, e.cnt, e.ovf);
      end
    end
  end

  task automatic idle();
    @(negedge CLK);
    a_push = 0; a_pop = 0; a_rv = 0; a_pt = '0;
    b_push = 0; b_pop = 0; b_rv = 0; b_pt = '0;
  endtask

  task automatic step(input string nm, input bit inst, input logic ps, input logic [W-1:0] pt,
                      input logic pp, input logic rv, input logic [2:0] rtos,
                      input logic [3:0] rcnt, input logic [W-1:0] rtgt,
                      input logic [W-1:0] et, input logic ev, input logic [2:0] etos,
                      input logic [3:0] ecnt, input logic eo);
    exp_t e;
    @(negedge CLK);
    a_push = 0; a_pop = 0; a_rv = 0;
    b_push = 0; b_pop = 0; b_rv = 0;
    if (!inst) begin
      a_push = ps; a_pt = pt; a_pop = pp; a_rv = rv; a_rtos = rtos; a_rcnt = rcnt; a_rtgt = rtgt;
    end else begin
      b_push = ps; b_pt = pt; b_pop = pp; b_rv = rv; b_rtos = rtos; b_rcnt = rcnt; b_rtgt = rtgt;
    end
    e.name = nm; e.inst = inst; e.top = et; e.vld = ev; e.tos = etos; e.cnt = ecnt; e.ovf = eo;
    sb_q.push_back(e);
  endtask

  task automatic push(input string nm, input bit inst, input logic [W-1:0] pt,
                      input logic [W-1:0] et, input logic ev, input logic [2:0] etos,
                      input logic [3:0] ecnt, input logic eo);
    step(nm, inst, 1, pt, 0, 0, 3'd0, 4'd0, '0, et, ev, etos, ecnt, eo);
  endtask

  task automatic pop(input string nm, input bit inst, input logic [W-1:0] et,
                     input logic ev, input logic [2:0] etos, input logic [3:0] ecnt);
    step(nm, inst, 0, '0, 1, 0, 3'd0, 4'd0, '0, et, ev, etos, ecnt, 0);
  endtask

  task automatic clean_a();
    step("restore_clean", 0, 0, '0, 0, 1, 3'd0, 4'd0, '0, '0, 0, 3'd0, 4'd0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nRST = 0;
    a_push = 0; a_pop = 0; a_rv = 0; a_pt = '0; a_rtos = '0; a_rcnt = '0; a_rtgt = '0;
    b_push = 0; b_pop = 0; b_rv = 0; b_pt = '0; b_rtos = '0; b_rcnt = '0; b_rtgt = '0;
    #12 nRST = 1;

    // Reset state, then basic push/pop
    step("reset_state", 0, 0, '0, 0, 0, 3'd0, 4'd0, '0, '0, 0, 3'd0, 4'd0, 0);
    push("push_100", 0, 31'h100, 31'h100, 1, 3'd1, 4'd1, 0);
    push("push_200", 0, 31'h200, 31'h200, 1, 3'd2, 4'd2, 0);
    push("push_300", 0, 31'h300, 31'h300, 1, 3'd3, 4'd3, 0);
    pop("pop_to_200", 0, 31'h200, 1, 3'd2, 4'd2);
    pop("pop_to_100", 0, 31'h100, 1, 3'd1, 4'd1);
    pop("pop_empty", 0, 31'h0, 0, 3'd0, 4'd0);

    // Underflow: pointer wraps to 7, count stays 0, entry 7 untouched
    pop("underflow", 0, 31'h0, 0, 3'd7, 4'd0);
    clean_a();

    // Tail-call replace at count 2, then at count 0
    push("push_a", 0, 31'hA, 31'hA, 1, 3'd1, 4'd1, 0);
    push("push_b", 0, 31'hB, 31'hB, 1, 3'd2, 4'd2, 0);
    step("pushpop_abc", 0, 1, 31'hABC, 1, 0, 3'd0, 4'd0, '0, 31'hABC, 1, 3'd2, 4'd2, 0);
    pop("pop_after_pp", 0, 31'hA, 1, 3'd1, 4'd1);
    pop("pop_to_zero", 0, 31'h0, 0, 3'd0, 4'd0);
    step("pushpop_empty", 0, 1, 31'h77, 1, 0, 3'd0, 4'd0, '0, 31'h77, 1, 3'd0, 4'd1, 0);

    // Checkpoint at tos=2/count=2/top=0x200, wrong path, restore with push ignored
    clean_a();
    push("ck_push_100", 0, 31'h100, 31'h100, 1, 3'd1, 4'd1, 0);
    push("ck_push_200", 0, 31'h200, 31'h200, 1, 3'd2, 4'd2, 0);
    push("wp_push_900", 0, 31'h900, 31'h900, 1, 3'd3, 4'd3, 0);
    push("wp_push_a00", 0, 31'hA00, 31'hA00, 1, 3'd4, 4'd4, 0);
    pop("wp_pop", 0, 31'h900, 1, 3'd3, 4'd3);
    step("restore_w_push", 0, 1, 31'hDEAD, 0, 1, 3'd2, 4'd2, 31'h200, 31'h200, 1, 3'd2, 4'd2, 0);
    pop("pop_after_rst", 0, 31'h100, 1, 3'd1, 4'd1);

    // Overflow, circular mode: value 1 is overwritten by 9
    clean_a();
    for (int i = 1; i <= 8; i++)
      push("wrap_fill", 0, 31'(i), 31'(i), 1, 3'(i), 4'(i), 0);
    push("wrap_overflow", 0, 31'd9, 31'd9, 1, 3'd1, 4'd8, 1);
    for (int k = 1; k <= 8; k++)
      pop("wrap_drain", 0, (k == 8) ? 31'd9 : 31'(9 - k), (k < 8), 3'(9 - k), 4'(8 - k));

    // Overflow, drop mode: the 9th push leaves the stack untouched
    for (int i = 1; i <= 8; i++)
      push("drop_fill", 1, 31'(i), 31'(i), 1, 3'(i), 4'(i), 0);
    push("drop_overflow", 1, 31'd9, 31'd8, 1, 3'd0, 4'd8, 1);
    pop("drop_pop", 1, 31'd7, 1, 3'd7, 4'd7);

    // Asynchronous reset between clock edges
    idle();
    #2 nRST = 0;
    #1;
    check_outs("async_rst_wrap", 0, '0, 0, 3'd0, 4'd0, 0);
    check_outs("async_rst_drop", 1, '0, 0, 3'd0, 4'd0, 0);
    #4 nRST = 1;
    step("post_reset", 0, 0, '0, 0, 0, 3'd0, 4'd0, '0, '0, 0, 3'd0, 4'd0, 0);
    idle();
    @(posedge CLK);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
